// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory-slave state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    DATA = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } slv_state_e;

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised storage with an asynchronous read port and byte-enabled
// synchronous writes sharing one address.
module ahb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BYTES-1:0]      wstrb,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wstrb[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: transfer FSM, programmable wait states, error decode
// with a two-cycle ERROR response, and byte-lane write masking.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    Hclk,
  input  logic                    Hreset,
  input  logic [ADDR_WIDTH-1:0]   Haddr,
  input  logic [1:0]              Htrans,
  input  logic                    Hwrite,
  input  logic [2:0]              Hsize,
  input  logic [2:0]              Hburst,
  input  logic [DATA_WIDTH-1:0]   HWdata,
  input  logic [DATA_WIDTH/8-1:0] Hstrob,
  input  logic                    Hsel,
  input  logic                    Hready,
  output logic [DATA_WIDTH-1:0]   HRdata,
  output logic                    Hreadyout,
  output logic [1:0]              Hresp
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BB    = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  slv_state_e            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic                  err_q;
  logic [3:0]            cnt;
  logic                  hreadyout_q;
  logic [1:0]            hresp_q;

  logic                  can_accept;
  logic                  accept;
  logic                  addr_err;
  logic                  wr_en;
  logic [BYTES-1:0]      wr_mask;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused;

  // Oversized, misaligned or beyond-depth accesses are answered with ERROR.
  function automatic logic decode_err(input logic [ADDR_WIDTH-1:0] a,
                                      input logic [2:0]            sz);
    logic [7:0] align_mask;
    align_mask = (8'd1 << sz) - 8'd1;
    return (sz > 3'(BB)) ||
           ((a[7:0] & align_mask) != 8'd0) ||
           (|a[ADDR_WIDTH-1:BB+IDX_W]);
  endfunction

  function automatic logic [BYTES-1:0] lane_mask(input logic [BB-1:0] lo,
                                                 input logic [2:0]    sz);
    logic [BYTES-1:0] m;
    int n;
    int base;
    n    = 1 << sz;
    base = int'(lo) & ~(n - 1);
    for (int i = 0; i < BYTES; i++) begin
      m[i] = (i >= base) && (i < base + n);
    end
    return m;
  endfunction

  assign can_accept = (state == IDLE) || (state == DATA) || (state == ERR2);
  assign accept     = can_accept && Hsel && Hready && Htrans[1];
  assign addr_err   = decode_err(Haddr, Hsize);

  // Transfer FSM with phase registers and registered handshake outputs.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state       <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'b000;
      err_q       <= 1'b0;
      cnt         <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state)
        IDLE, DATA, ERR2: begin
          if (accept) begin
            addr_q  <= Haddr;
            write_q <= Hwrite;
            size_q  <= Hsize;
            err_q   <= addr_err;
            if (addr_err) begin
              state       <= ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state       <= WAIT;
              cnt         <= 4'(WAIT_STATES - 1);
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_OKAY;
            end else begin
              state       <= DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
            end
          end else begin
            state       <= IDLE;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state       <= DATA;
            hreadyout_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ERR1: begin
          state       <= ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state       <= IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // A write lands on the edge closing its DATA cycle; reset on that edge aborts it.
  assign wr_en   = (state == DATA) && write_q && !err_q && !Hreset;
  assign wr_mask = lane_mask(addr_q[BB-1:0], size_q) & Hstrob;

  ahb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (Hclk),
    .we    (wr_en),
    .addr  (addr_q[BB +: IDX_W]),
    .wdata (HWdata),
    .wstrb (wr_mask),
    .rdata (mem_rdata)
  );

  assign HRdata    = ((state == DATA) && !write_q) ? mem_rdata : '0;
  assign Hreadyout = hreadyout_q;
  assign Hresp     = hresp_q;

  assign unused = ^{Hburst, Htrans[0], addr_q[ADDR_WIDTH-1:BB+IDX_W]};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: three slaves (0, 3 and 5 wait states) on a shared bus,
// driven one at a time as the selected slave.
module tb_ahb_mem_slave;
  import ahb_pkg::*;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [2:0]  Hburst;
  logic [31:0] HWdata;
  logic [3:0]  Hstrob;
  logic [2:0]  sel;
  logic        Hready;

  logic [31:0] rd0, rd3, rd5, rd_a;
  logic        ro0, ro3, ro5, ro_a;
  logic [1:0]  rs0, rs3, rs5, rs_a;
  int          active;
  int          tests = 0;
  int          fails = 0;

  always #5 Hclk = ~Hclk;

  always_comb begin
    case (active)
      0: begin rd_a = rd0; ro_a = ro0; rs_a = rs0; end
      1: begin rd_a = rd3; ro_a = ro3; rs_a = rs3; end
      default: begin rd_a = rd5; ro_a = ro5; rs_a = rs5; end
    endcase
  end
  assign Hready = ro_a;

  ahb_mem_slave #(.WAIT_STATES(0)) u0 (
    .Hclk(Hclk), .Hreset(Hreset), .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite),
    .Hsize(Hsize), .Hburst(Hburst), .HWdata(HWdata), .Hstrob(Hstrob), .Hsel(sel[0]),
    .Hready(Hready), .HRdata(rd0), .Hreadyout(ro0), .Hresp(rs0));
  ahb_mem_slave #(.WAIT_STATES(3)) u3 (
    .Hclk(Hclk), .Hreset(Hreset), .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite),
    .Hsize(Hsize), .Hburst(Hburst), .HWdata(HWdata), .Hstrob(Hstrob), .Hsel(sel[1]),
    .Hready(Hready), .HRdata(rd3), .Hreadyout(ro3), .Hresp(rs3));
  ahb_mem_slave #(.WAIT_STATES(5)) u5 (
    .Hclk(Hclk), .Hreset(Hreset), .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite),
    .Hsize(Hsize), .Hburst(Hburst), .HWdata(HWdata), .Hstrob(Hstrob), .Hsel(sel[2]),
    .Hready(Hready), .HRdata(rd5), .Hreadyout(ro5), .Hresp(rs5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic idle_bus();
    Htrans = HTRANS_IDLE;
    sel    = 3'b000;
    Hwrite = 1'b0;
    Haddr  = 32'h0;
    Hsize  = HSIZE_WORD;
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                         input logic [1:0] tr);
    Haddr  = a;
    Htrans = tr;
    Hwrite = wr;
    Hsize  = sz;
    sel    = 3'(1 << active);
  endtask

  // One complete OKAY transfer with ws wait cycles; checks every data-phase cycle.
  task automatic xfer(input string tag, input int ws, input logic [31:0] a, input logic wr,
                      input logic [2:0] sz, input logic [31:0] wd, input logic [3:0] st,
                      input logic [31:0] exp_rd);
    addr_ph(a, wr, sz, HTRANS_NONSEQ);
    chk({tag, "_aready"}, 32'(ro_a), 32'd1);
    tick();
    idle_bus();
    HWdata = wd;
    Hstrob = st;
    for (int i = 0; i < ws; i++) begin
      chk({tag, "_wait_ready"}, 32'(ro_a), 32'd0);
      chk({tag, "_wait_resp"}, 32'(rs_a), 32'(HRESP_OKAY));
      tick();
    end
    chk({tag, "_ready"}, 32'(ro_a), 32'd1);
    chk({tag, "_resp"}, 32'(rs_a), 32'(HRESP_OKAY));
    chk({tag, "_rdata"}, rd_a, wr ? 32'h0 : exp_rd);
    tick();
  endtask

  task automatic err_xfer(input string tag, input logic [31:0] a, input logic wr,
                          input logic [2:0] sz);
    addr_ph(a, wr, sz, HTRANS_NONSEQ);
    tick();
    idle_bus();
    HWdata = 32'hFFFF_FFFF;
    Hstrob = 4'hF;
    chk({tag, "_err1_ready"}, 32'(ro_a), 32'd0);
    chk({tag, "_err1_resp"}, 32'(rs_a), 32'(HRESP_ERROR));
    chk({tag, "_err1_rdata"}, rd_a, 32'h0);
    tick();
    chk({tag, "_err2_ready"}, 32'(ro_a), 32'd1);
    chk({tag, "_err2_resp"}, 32'(rs_a), 32'(HRESP_ERROR));
    tick();
    chk({tag, "_after_resp"}, 32'(rs_a), 32'(HRESP_OKAY));
    chk({tag, "_after_ready"}, 32'(ro_a), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    active = 0;
    Hreset = 1'b1;
    Hburst = 3'b000;
    HWdata = 32'h0;
    Hstrob = 4'h0;
    idle_bus();
    repeat (3) tick();
    chk("rst_ready0", 32'(ro0), 32'd1);
    chk("rst_resp0", 32'(rs0), 32'(HRESP_OKAY));
    chk("rst_rdata0", rd0, 32'h0);
    chk("rst_ready3", 32'(ro3), 32'd1);
    chk("rst_ready5", 32'(ro5), 32'd1);
    Hreset = 1'b0;
    tick();

    // Write then immediately read the same word, zero wait states.
    addr_ph(32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    chk("b2b_a_ready", 32'(ro_a), 32'd1);
    tick();
    HWdata = 32'hDEAD_BEEF;
    Hstrob = 4'hF;
    addr_ph(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    chk("b2b_w_ready", 32'(ro_a), 32'd1);
    chk("b2b_w_rdata", rd_a, 32'h0);
    tick();
    idle_bus();
    chk("b2b_r_ready", 32'(ro_a), 32'd1);
    chk("b2b_r_resp", 32'(rs_a), 32'(HRESP_OKAY));
    chk("b2b_r_rdata", rd_a, 32'hDEAD_BEEF);
    tick();
    chk("b2b_idle_rdata", rd_a, 32'h0);

    // Byte, halfword and strobe-masked writes.
    xfer("preset0", 0, 32'h0, 1'b1, HSIZE_WORD, 32'h0BAD_F00D, 4'hF, 32'h0);
    xfer("preset10", 0, 32'h10, 1'b1, HSIZE_WORD, 32'h1122_3344, 4'hF, 32'h0);
    xfer("bytewr", 0, 32'h13, 1'b1, HSIZE_BYTE, 32'hAA00_0000, 4'hF, 32'h0);
    xfer("byterd", 0, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 32'hAA22_3344);
    xfer("zstrb_wr", 0, 32'h10, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, 4'h0, 32'h0);
    xfer("zstrb_rd", 0, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 32'hAA22_3344);
    xfer("halfwr", 0, 32'h12, 1'b1, HSIZE_HALF, 32'h5566_0000, 4'hF, 32'h0);
    xfer("pstrb_wr", 0, 32'h10, 1'b1, HSIZE_WORD, 32'h0000_0000, 4'h1, 32'h0);
    xfer("halfrd", 0, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 32'h5566_3300);

    // Two pipelined reads of different words.
    addr_ph(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    addr_ph(32'h0, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    chk("pipe_rd1", rd_a, 32'h5566_3300);
    tick();
    idle_bus();
    chk("pipe_rd2", rd_a, 32'h0BAD_F00D);
    chk("pipe_ready", 32'(ro_a), 32'd1);
    tick();

    // Error responses; word 0 is where these would alias if written.
    err_xfer("oor_wr", 32'h1000, 1'b1, HSIZE_WORD);
    err_xfer("unal_wr", 32'h2, 1'b1, HSIZE_WORD);
    err_xfer("size_wr", 32'h0, 1'b1, HSIZE_DWORD);
    err_xfer("oor_rd", 32'h1000, 1'b0, HSIZE_WORD);
    xfer("err_mem", 0, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 32'h0BAD_F00D);

    // BUSY and IDLE while selected create no transfer.
    addr_ph(32'h10, 1'b1, HSIZE_WORD, HTRANS_BUSY);
    tick();
    idle_bus();
    HWdata = 32'h0;
    Hstrob = 4'hF;
    chk("busy_ready", 32'(ro_a), 32'd1);
    chk("busy_resp", 32'(rs_a), 32'(HRESP_OKAY));
    chk("busy_rdata", rd_a, 32'h0);
    addr_ph(32'h10, 1'b1, HSIZE_WORD, HTRANS_IDLE);
    tick();
    idle_bus();
    chk("idle_ready", 32'(ro_a), 32'd1);
    chk("idle_rdata", rd_a, 32'h0);
    tick();
    xfer("busy_mem", 0, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 32'h5566_3300);

    // Three wait states; error latency stays two cycles.
    active = 1;
    xfer("ws3_wr", 3, 32'h20, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 4'hF, 32'h0);
    xfer("ws3_rd", 3, 32'h20, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 32'hCAFE_F00D);
    err_xfer("ws3_err", 32'h1000, 1'b0, HSIZE_WORD);

    // Reset in the middle of a waited write discards it.
    active = 2;
    xfer("ws5_wr", 5, 32'h30, 1'b1, HSIZE_WORD, 32'h1234_5678, 4'hF, 32'h0);
    addr_ph(32'h30, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    idle_bus();
    HWdata = 32'hFFFF_FFFF;
    Hstrob = 4'hF;
    chk("rstmid_w1", 32'(ro_a), 32'd0);
    tick();
    chk("rstmid_w2", 32'(ro_a), 32'd0);
    Hreset = 1'b1;
    tick();
    Hreset = 1'b0;
    chk("rstmid_ready", 32'(ro_a), 32'd1);
    chk("rstmid_resp", 32'(rs_a), 32'(HRESP_OKAY));
    chk("rstmid_rdata", rd_a, 32'h0);
    repeat (6) tick();
    xfer("rstmid_mem", 5, 32'h30, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- Parametrised AHB-Lite memory slave with configurable wait states, byte-lane writes and a two-cycle ERROR response.
- Generalises the fixed single-slave wrapper: width, depth and latency are parameters, and the internal storage array is built in.
- Connects directly to the AHB interconnect: decoder Hsel, mux Hready, return path HRdata/Hreadyout/Hresp.

Parameters:
ADDR_WIDTH, 32, Haddr width
DATA_WIDTH, 32, data bus width; one of 32 or 64
MEM_DEPTH, 1024, storage depth in DATA_WIDTH words; power of two
WAIT_STATES, 0, extra data-phase cycles with Hreadyout=0 on every OKAY transfer; 0..15

Ports:
Hclk  in  1  sole clock, rising edge
Hreset  in  1  synchronous, active-high reset
Haddr  in  ADDR_WIDTH  byte address (address phase)
Htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
Hwrite  in  1  1=write
Hsize  in  3  log2 of transfer bytes
Hburst  in  3  accepted for compatibility; no effect on behaviour
HWdata  in  DATA_WIDTH  write data (data phase)
Hstrob  in  DATA_WIDTH/8  byte write strobes (data phase)
Hsel  in  1  slave select
Hready  in  1  bus ready (muxed Hreadyout)
HRdata  out  DATA_WIDTH  read data
Hreadyout  out  1  slave ready
Hresp  out  2  OKAY=00, ERROR=01

Behaviour:
- Interface: one clock, Hclk; Hreset is synchronous and active-high. All state updates on the Hclk rising edge only.
- Reset:
  - FSM goes to IDLE; Hreadyout=1, Hresp=OKAY, HRdata=0; all phase registers clear.
  - Memory contents are not reset.
  - Reset asserted mid-transfer aborts it; any pending write is discarded.
- Address phase:
  - Accept when Hsel && Hready && Htrans[1].
  - Register addr_q, write_q, size_q, and the error flag err_q.
  - err_q=1 if any of:
    - Hsize > log2(DATA_WIDTH/8);
    - Haddr is not aligned to 2^Hsize;
    - word index Haddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] >= MEM_DEPTH.
  - IDLE, BUSY or unselected cycles create no transfer; the next cycle is a zero-wait OKAY response.
- FSM states and transitions:
  - IDLE: Hreadyout=1, Hresp=OKAY.
    - Accepted transfer with err_q=1 -> ERR1.
    - Accepted transfer with err_q=0 and WAIT_STATES>0 -> WAIT, with cnt loaded to WAIT_STATES-1.
    - Accepted transfer with err_q=0 and WAIT_STATES=0 -> DATA.
  - WAIT: Hreadyout=0, Hresp=OKAY. cnt decrements each cycle; at cnt=0 -> DATA.
  - DATA: Hreadyout=1, Hresp=OKAY. Transfer completes this cycle. A new accepted transfer goes to ERR1, WAIT or DATA as from IDLE; otherwise -> IDLE.
  - ERR1: Hreadyout=0, Hresp=ERROR -> ERR2.
  - ERR2: Hreadyout=1, Hresp=ERROR. A new accepted transfer is handled as from IDLE; otherwise -> IDLE.
- Latency:
  - OKAY transfer: data phase lasts WAIT_STATES+1 cycles.
  - ERROR transfer: data phase lasts exactly 2 cycles, regardless of WAIT_STATES.
- Write:
  - Committed at the end of the DATA cycle only; no write in WAIT, ERR1 or ERR2.
  - Byte-lane mask = (lanes selected by size_q and addr_q low bits) & Hstrob.
  - An all-zero mask is still an OKAY transfer and writes nothing.
  - Errored writes never modify memory.
- Read:
  - HRdata = full memory word at addr_q (asynchronous array read) during the DATA cycle of a read; HRdata=0 in all other cycles.
  - Write followed by back-to-back read of the same word returns the new data, because the write commits on the edge that begins the read's data phase.
- Pipelining: with WAIT_STATES=0, back-to-back NONSEQ/SEQ transfers run at one per cycle.
- Hsel deasserted during a pending data phase does not cancel it; the phase always completes.

Decomposition:
- Package ahb_pkg:
  - HTRANS_* and HRESP_* constants;
  - HSIZE_* constants;
  - enum slv_state_e {IDLE, WAIT, DATA, ERR1, ERR2}.
- Sub-module ahb_mem_array: MEM_DEPTH x DATA_WIDTH storage; asynchronous read port; synchronous write with per-byte enable.
- Top-level block keeps the FSM, wait counter, phase registers, error decode and lane-mask generation.

Test Plan:
- WAIT_STATES=0, DATA_WIDTH=32: write 0xDEADBEEF to 0x10, then immediately read 0x10 -> Hreadyout=1 every cycle; the read data phase returns HRdata=0xDEADBEEF with Hresp=OKAY.
- WAIT_STATES=3: read 0x20 -> Hreadyout=0 for 3 cycles, then 1 with data; Hresp=OKAY throughout.
- Byte write: Hsize=0, Haddr=0x13, HWdata=0xAA000000, Hstrob=4'hF over a word preset to 0x11223344 -> word reads 0xAA223344.
- Out-of-range access (MEM_DEPTH=1024, Haddr=0x1000) and unaligned access (Hsize=2, Haddr=0x2) -> each gives ERR1 (Hreadyout=0, Hresp=01) then ERR2 (Hreadyout=1, Hresp=01); memory unchanged.
- Htrans=BUSY and IDLE with Hsel=1 -> no memory change; zero-wait OKAY response; HRdata=0.
- Hreset=1 during WAIT of a write with WAIT_STATES=5 -> next cycle Hreadyout=1, Hresp=00, HRdata=0; target word keeps its old value.
